// File: rtl/cross_bar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cross_bar_pkg
// Brief    : Shared types for the crossbar slave responder.
// Revision : 1.0 - initial release
// ============================================================================
package cross_bar_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_e;

  // Slave-select field occupies the top SEL_W address bits:
  // addr[ADDR_W-1 -: SEL_W]. The responder ignores it.
  localparam int SEL_W = 2;

  // Width of the latency down-counter (LATENCY tops out at 15).
  localparam int CNT_W = 4;

endpackage : cross_bar_pkg
`default_nettype wire

// File: rtl/cross_bar_slave_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : cross_bar_slave_resp_if
// Brief    : Crossbar slave-port bus (request side from the crossbar,
//            ack/rdata back from the responder).
// Revision : 1.0 - initial release
// ============================================================================
interface cross_bar_slave_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              slv_req;
  logic [ADDR_W-1:0] slv_addr;
  logic              slv_cmd;
  logic [DATA_W-1:0] slv_wdata;
  logic              slv_ack;
  logic [DATA_W-1:0] slv_rdata;

  modport master (
    output slv_req, slv_addr, slv_cmd, slv_wdata,
    input  slv_ack, slv_rdata
  );

  modport slave (
    input  slv_req, slv_addr, slv_cmd, slv_wdata,
    output slv_ack, slv_rdata
  );
endinterface : cross_bar_slave_resp_if
`default_nettype wire

// File: rtl/cross_bar_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : cross_bar_slave_ram
// Brief    : Single-port DEPTH x DATA_W memory, synchronous write and
//            registered read. The read register is cleared by rst; the
//            array itself is never reset.
// Revision : 1.0 - initial release
// ============================================================================
module cross_bar_slave_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register: updated only by a read, so writes leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule : cross_bar_slave_ram
`default_nettype wire

// File: rtl/cross_bar_slave_resp.sv
`default_nettype none
// ============================================================================
// Module   : cross_bar_slave_resp
// Brief    : Crossbar slave-port responder. Acks each request after a fixed
//            latency and serves reads/writes from an internal word memory.
// Revision : 1.0 - initial release
// ============================================================================
module cross_bar_slave_resp
  import cross_bar_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  cross_bar_slave_resp_if.slave  bus
);

  localparam int               IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  resp_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              capture;
  logic [IDX_W-1:0]  idx_q;
  cmd_e              cmd_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // Slave-select and the bits above the word index (plus byte offset)
  // play no part in addressing; the index wraps on the low bits.
  logic unused_sel;
  logic unused_addr_bits;
  assign unused_sel       = ^bus.slv_addr[ADDR_W-1 -: SEL_W];
  assign unused_addr_bits = ^{bus.slv_addr[ADDR_W-SEL_W-1:IDX_W+2], bus.slv_addr[1:0]};

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; WAIT moves to ACK when the decremented count hits 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.slv_req) begin
          capture   = 1'b1;
          cnt_nxt   = LAT_M1;
          state_nxt = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!bus.slv_req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = ACK;
          end
        end
      end
      ACK: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Request capture at acceptance; reset wins over a simultaneous req.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      cmd_q   <= CMD_READ;
      wdata_q <= '0;
    end else if (capture) begin
      idx_q   <= bus.slv_addr[IDX_W+1:2];
      cmd_q   <= cmd_e'(bus.slv_cmd);
      wdata_q <= bus.slv_wdata;
    end
  end

  // Memory access happens only in ACK, and a reset in that cycle drops it.
  assign ram_en = (state == ACK) && !rst;
  assign ram_we = (cmd_q == CMD_WRITE);

  cross_bar_slave_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.slv_ack   = (state == ACK);
  assign bus.slv_rdata = ram_rdata;

endmodule : cross_bar_slave_resp
`default_nettype wire

// File: tb/tb_cross_bar_slave_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cross_bar_slave_resp
// Brief    : Directed self-checking bench for cross_bar_slave_resp
//            (LATENCY=2, MEM_DEPTH=256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cross_bar_slave_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  cross_bar_slave_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cross_bar_slave_resp #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_DEPTH (256),
    .LATENCY   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance one cycle; sample point sits 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a request and wait (bounded) for ack; the number of cycles from
  // driving to ack must equal exp_lat. Returns in the ack cycle.
  task automatic xfer(input string tag, input logic c, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat, input bit keep);
    int n;
    n = 0;
    bus.slv_req   = 1'b1;
    bus.slv_cmd   = c;
    bus.slv_addr  = a;
    bus.slv_wdata = d;
    do begin
      tick();
      n++;
    end while (bus.slv_ack !== 1'b1 && n < 20);
    check({tag, "_lat"}, n, exp_lat);
    if (!keep) bus.slv_req = 1'b0;
  endtask

  initial begin
    bus.slv_req   = 1'b0;
    bus.slv_cmd   = 1'b0;
    bus.slv_addr  = '0;
    bus.slv_wdata = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_ack", bus.slv_ack, 1'b0);
    check("rst_rdata", bus.slv_rdata, 32'h0);
    rst = 1'b0;

    // 1: write 5 to index 1 (select bits set)
    xfer("wr1", 1'b1, 32'hC000_0004, 32'd5, 2, 1'b0);
    check("wr1_rdata_in_ack", bus.slv_rdata, 32'h0);
    tick();
    check("wr1_ack_one_cycle", bus.slv_ack, 1'b0);
    check("wr1_rdata_after", bus.slv_rdata, 32'h0);

    // 2: read back index 1
    tick();
    xfer("rd1", 1'b0, 32'hC000_0004, 32'h0, 2, 1'b0);
    tick();
    check("rd1_rdata", bus.slv_rdata, 32'd5);
    check("rd1_ack_low", bus.slv_ack, 1'b0);
    tick();
    tick();
    check("rd1_rdata_held", bus.slv_rdata, 32'd5);

    // 3: back-to-back write then read, req held across ack
    xfer("b2b_wr", 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 2, 1'b1);
    xfer("b2b_rd", 1'b0, 32'h0000_0008, 32'h0, 3, 1'b0);
    check("b2b_rdata_before", bus.slv_rdata, 32'd5);
    tick();
    check("b2b_rdata", bus.slv_rdata, 32'hDEAD_BEEF);

    // 4: index wrap (256 -> 0) and ignored select bits
    xfer("wrap_wr", 1'b1, 32'h0000_0400, 32'd7, 2, 1'b0);
    tick();
    xfer("wrap_rd", 1'b0, 32'h4000_0000, 32'h0, 2, 1'b0);
    tick();
    check("wrap_rdata", bus.slv_rdata, 32'd7);

    // 5: abort a read by dropping req in WAIT
    bus.slv_req  = 1'b1;
    bus.slv_cmd  = 1'b0;
    bus.slv_addr = 32'h0000_0008;
    tick();
    bus.slv_req = 1'b0;
    check("abort_ack_wait", bus.slv_ack, 1'b0);
    tick();
    check("abort_ack_next", bus.slv_ack, 1'b0);
    tick();
    check("abort_ack_late", bus.slv_ack, 1'b0);
    check("abort_rdata", bus.slv_rdata, 32'd7);
    xfer("post_abort_rd", 1'b0, 32'h0000_0008, 32'h0, 2, 1'b0);
    tick();
    check("post_abort_rdata", bus.slv_rdata, 32'hDEAD_BEEF);

    // 6: reset in WAIT of a write of 9 to index 3 (holds 0x33 beforehand)
    xfer("pre_wr3", 1'b1, 32'h0000_000C, 32'h33, 2, 1'b0);
    tick();
    bus.slv_req   = 1'b1;
    bus.slv_cmd   = 1'b1;
    bus.slv_addr  = 32'h0000_000C;
    bus.slv_wdata = 32'd9;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.slv_req = 1'b0;
    check("rstwait_ack", bus.slv_ack, 1'b0);
    check("rstwait_rdata", bus.slv_rdata, 32'h0);
    tick();
    xfer("rstwait_rd", 1'b0, 32'h0000_000C, 32'h0, 2, 1'b0);
    tick();
    check("rstwait_rd_data", bus.slv_rdata, 32'h33);

    // Reset during ACK of a write drops that write
    xfer("rstack_wr", 1'b1, 32'h0000_000C, 32'h55, 2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstack_ack", bus.slv_ack, 1'b0);
    xfer("rstack_rd", 1'b0, 32'h0000_000C, 32'h0, 2, 1'b0);
    tick();
    check("rstack_rd_data", bus.slv_rdata, 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cross_bar_slave_resp
`default_nettype wire
